// File: rtl/shader_pkg.sv
// rtl/shader_pkg.sv - shared types and width helpers for the warp scoreboard
package shader_pkg;

  localparam int SB_NUM_WARPS   = 8;
  localparam int SB_NUM_REGS    = 256;
  localparam int SB_NUM_SRC     = 3;
  localparam int SB_MAX_PENDING = 16;

  typedef logic [$clog2(SB_NUM_WARPS)-1:0] warp_id_t;
  typedef logic [$clog2(SB_NUM_REGS)-1:0]  reg_idx_t;

  typedef struct packed {
    warp_id_t                                   warp;
    logic                                       dst_en;
    reg_idx_t                                   dst;
    logic [SB_NUM_SRC-1:0]                      src_en;
    logic [SB_NUM_SRC*$clog2(SB_NUM_REGS)-1:0]  src;
  } sb_iss_req_t;

  function automatic int sb_cnt_w(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

  localparam int SB_CNT_W = sb_cnt_w(SB_MAX_PENDING);

endpackage

// File: rtl/scoreboard_warp_bank.sv
// rtl/scoreboard_warp_bank.sv - pending-write vector and outstanding count for one warp
module scoreboard_warp_bank #(
  parameter int NUM_REGS = 256,
  parameter int CNT_W    = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        set_i,
  input  logic [$clog2(NUM_REGS)-1:0] set_idx_i,
  input  logic [NUM_REGS-1:0]         clr_mask_i,
  input  logic                        flush_i,
  output logic [NUM_REGS-1:0]         pending_o,
  output logic [CNT_W-1:0]            cnt_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] cleared;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    dec;
  logic                inc;

  // A set and a clear on the same bit leave it pending, so that clear is not counted.
  always_comb begin
    set_mask = '0;
    if (set_i) set_mask[set_idx_i] = 1'b1;
    cleared = pend_q & clr_mask_i & ~set_mask;
    inc     = set_i && !pend_q[set_idx_i];
    dec     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dec = dec + CNT_W'(cleared[i]);
    end
    if (flush_i) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      pend_d = (pend_q & ~clr_mask_i) | set_mask;
      cnt_d  = cnt_q + CNT_W'(inc) - dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_o = pend_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/warp_scoreboard.sv
// rtl/warp_scoreboard.sv - per-warp RAW/WAW hazard scoreboard; SB_WB_BYPASS_EN forwards same-cycle writebacks to RAW
module warp_scoreboard
  import shader_pkg::*;
#(
  parameter int NUM_WARPS    = 8,
  parameter int NUM_REGS     = 256,
  parameter int NUM_SRC      = 3,
  parameter int NUM_WB_PORTS = 2,
  parameter int MAX_PENDING  = 16
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            iss_valid,
  output logic                                            iss_ready,
  input  logic [$clog2(NUM_WARPS)-1:0]                    iss_warp,
  input  logic                                            iss_dst_en,
  input  logic [$clog2(NUM_REGS)-1:0]                     iss_dst,
  input  logic [NUM_SRC-1:0]                              iss_src_en,
  input  logic [NUM_SRC*$clog2(NUM_REGS)-1:0]             iss_src,
  input  logic [NUM_WB_PORTS-1:0]                         wb_valid,
  input  logic [NUM_WB_PORTS*$clog2(NUM_WARPS)-1:0]       wb_warp,
  input  logic [NUM_WB_PORTS*$clog2(NUM_REGS)-1:0]        wb_reg,
  input  logic                                            flush_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]                    flush_warp,
  output logic [NUM_WARPS*$clog2(MAX_PENDING+1)-1:0]      warp_pending_cnt,
  output logic [NUM_WARPS-1:0]                            warp_idle,
  output logic [31:0]                                     hazard_stalls,
  output logic                                            err_wb_orphan
);

  localparam int WW = $clog2(NUM_WARPS);
  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = sb_cnt_w(MAX_PENDING);

  logic [NUM_REGS-1:0] pend     [NUM_WARPS];
  logic [CW-1:0]       cnt      [NUM_WARPS];
  logic [NUM_REGS-1:0] clr_mask [NUM_WARPS];

  logic          raw, waw, full, fl, accept, byp, orphan;
  logic [RW-1:0] src_r;
  logic [WW-1:0] wbw_r;
  logic [RW-1:0] wbr_r;
  logic [31:0]   stalls_q, stalls_d;
  logic          err_q, err_d;

  always_comb begin
    raw   = 1'b0;
    src_r = '0;
    byp   = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_r = iss_src[s*RW +: RW];
      byp   = 1'b0;
`ifdef SB_WB_BYPASS_EN
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (wb_valid[p] && wb_warp[p*WW +: WW] == iss_warp && wb_reg[p*RW +: RW] == src_r)
          byp = 1'b1;
      end
`endif
      if (iss_src_en[s] && pend[iss_warp][src_r] && !byp) raw = 1'b1;
    end
    waw       = iss_dst_en && pend[iss_warp][iss_dst];
    full      = iss_dst_en && (cnt[iss_warp] == CW'(MAX_PENDING));
    fl        = flush_valid && (flush_warp == iss_warp);
    iss_ready = !(raw || waw || full || fl);
    accept    = iss_valid && iss_ready;
  end

  // Writebacks into a warp being flushed are dropped silently, not reported as orphans.
  always_comb begin
    orphan = 1'b0;
    wbw_r  = '0;
    wbr_r  = '0;
    for (int w = 0; w < NUM_WARPS; w++) clr_mask[w] = '0;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      wbw_r = wb_warp[p*WW +: WW];
      wbr_r = wb_reg[p*RW +: RW];
      if (wb_valid[p]) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
          if (wbw_r == WW'(w)) clr_mask[w][wbr_r] = 1'b1;
        end
        if (!(flush_valid && flush_warp == wbw_r) && !pend[wbw_r][wbr_r]) orphan = 1'b1;
      end
    end
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_bank
    scoreboard_warp_bank #(
      .NUM_REGS (NUM_REGS),
      .CNT_W    (CW)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .set_i      (accept && iss_dst_en && (iss_warp == WW'(w))),
      .set_idx_i  (iss_dst),
      .clr_mask_i (clr_mask[w]),
      .flush_i    (flush_valid && (flush_warp == WW'(w))),
      .pending_o  (pend[w]),
      .cnt_o      (cnt[w])
    );
    assign warp_pending_cnt[w*CW +: CW] = cnt[w];
    assign warp_idle[w]                 = (cnt[w] == '0);
  end

  always_comb begin
    stalls_d = stalls_q;
    if (iss_valid && !iss_ready && stalls_q != 32'hFFFF_FFFF) stalls_d = stalls_q + 32'd1;
    err_d = err_q || orphan;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stalls_q <= '0;
      err_q    <= 1'b0;
    end else begin
      stalls_q <= stalls_d;
      err_q    <= err_d;
    end
  end

  assign hazard_stalls = stalls_q;
  assign err_wb_orphan = err_q;

endmodule

// File: doc/warp_scoreboard.md
Name: warp_scoreboard

Overview:
- Parametrised per-warp register scoreboard: next-generation hazard tracker for the shader issue stage.
- Tracks outstanding writes per (warp, register) and blocks issue on RAW/WAW hazards or per-warp pending-limit overflow.
- Accepts multiple writeback ports per cycle and supports per-warp flush.
- Sits between warp scheduler/decoder and the ALU/LSU dispatch; generalises warp count, register window, writeback ports and source-operand count.

Parameters:
- NUM_WARPS, 8: concurrent warps tracked.
- NUM_REGS, 256: registers per warp.
- NUM_SRC, 3: source operands checked per instruction (FMA/MADD need 3).
- NUM_WB_PORTS, 2: writeback ports (ALU + LSU).
- MAX_PENDING, 16: maximum outstanding writes per warp.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- iss_valid  in  1  issue request valid
- iss_ready  out  1  request may issue this cycle (combinational)
- iss_warp  in  $clog2(NUM_WARPS)  issuing warp
- iss_dst_en  in  1  instruction writes a destination
- iss_dst  in  $clog2(NUM_REGS)  destination register
- iss_src_en  in  NUM_SRC  per-source valid
- iss_src  in  NUM_SRC*$clog2(NUM_REGS)  source registers, packed
- wb_valid  in  NUM_WB_PORTS  writeback complete
- wb_warp  in  NUM_WB_PORTS*$clog2(NUM_WARPS)  writeback warp, packed
- wb_reg  in  NUM_WB_PORTS*$clog2(NUM_REGS)  writeback register, packed
- flush_valid  in  1  clear all pending state of one warp
- flush_warp  in  $clog2(NUM_WARPS)  warp to flush
- warp_pending_cnt  out  NUM_WARPS*$clog2(MAX_PENDING+1)  outstanding writes per warp
- warp_idle  out  NUM_WARPS  warp has zero pending writes
- hazard_stalls  out  32  cycles with iss_valid && !iss_ready
- err_wb_orphan  out  1  sticky: writeback to a non-pending register

Behaviour:
- Reset (async, rst=1):
  - all pending bits 0, warp_pending_cnt 0, warp_idle all 1;
  - hazard_stalls 0, err_wb_orphan 0;
  - iss_ready is combinational, so it is 1 under reset if iss_valid with no hazards.
- Hazards, computed from registered state:
  - raw = any enabled src pending in iss_warp;
  - waw = iss_dst_en && dst pending;
  - full = iss_dst_en && cnt[iss_warp]==MAX_PENDING;
  - fl = flush_valid && flush_warp==iss_warp.
- iss_ready = !(raw|waw|full|fl).
- iss_ready may depend on iss_* inputs; iss_valid must not depend on iss_ready.
- Accept = iss_valid && iss_ready. On accept with iss_dst_en, pending[warp][dst] is set next cycle and cnt is incremented. Issue-to-visible-hazard latency is 1 cycle.
- dst equal to a src: RAW is checked against pre-issue state only, so the request can issue.
- Writeback: each wb_valid port clears pending[warp][reg] next cycle, and cnt decrements once per distinct cleared bit.
- Two ports naming the same (warp, reg) in one cycle: one clear, one decrement.
- Writeback to a non-pending bit: ignored, and err_wb_orphan is set (sticky until reset).
- Same-cycle issue and writeback to the same (warp, reg): bit remains set (issue wins); cnt net unchanged.
- Flush: all pending bits of flush_warp clear next cycle and cnt goes to 0.
  - Writebacks to that warp in the same cycle are ignored, with no error flag.
  - Issue for that warp is blocked that cycle.
- Counter rules:
  - cnt never exceeds MAX_PENDING and never underflows;
  - hazard_stalls saturates at 32'hFFFF_FFFF.
- warp_idle[w] = (cnt[w]==0), registered-state derived.

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: a source whose (warp, reg) matches a valid writeback in the same cycle is not counted as a RAW hazard (same-cycle clear forwarding). WAW is not bypassed.
- Undefined: RAW uses registered state only; a dependent instruction issues no earlier than the cycle after writeback.

Decomposition:
- shader_pkg holds:
  - warp_id_t and reg_idx_t typedefs;
  - sb_iss_req_t struct (warp, dst_en, dst, src_en, src);
  - SB_CNT_W localparam function.
- Sub-module scoreboard_warp_bank, instantiated NUM_WARPS times:
  - holds the NUM_REGS pending vector and cnt;
  - takes set, clear-mask and flush inputs;
  - returns the pending vector.
- Top level does hazard muxing and stall counting.

Test Plan:
- Reset, then issue warp 0 dst=5 → next cycle, warp 0 src=5 iss_ready=0. wb warp 0 reg 5 → ready=1 one cycle later (same cycle with SB_WB_BYPASS_EN); hazard_stalls = stall cycles observed.
- Warp 1 dst=7 pending, reissue dst=7 → WAW stall. Warp 2 dst=7 → ready=1 (warp isolation).
- Issue 16 writes on warp 3 → cnt=16, 17th dst issue stalls. Same warp with dst_en=0 and no src hazard → ready=1.
- Both wb ports clear warp 4 reg 9 in same cycle → cnt drops by 1, err_wb_orphan stays 0. Later wb warp 4 reg 9 → err_wb_orphan=1.
- Warp 5 holds 3 pending; flush_warp=5 with concurrent wb on warp 5 and issue on warp 5 → issue blocked that cycle, cnt=0 next cycle, warp_idle[5]=1, no error.
- Assert rst mid-operation with 10 pending across warps → all outputs return to reset values asynchronously; post-reset issue is hazard-free.
